// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master arbiter in front of a single-port synchronous RAM.
// Grants are combinational. A master can hold exclusive ownership through its
// lock input. Read-valid and error responses arrive one cycle after the
// transfer that caused them.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin priority on
// conflicts. By default priority is fixed and master 0 wins every conflict.
`timescale 1ns/1ps
module ram_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16,
  parameter int RAM_DEPTH = 1024
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic [15:0]       i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  input  logic              i_m0_lock,
  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic [15:0]       i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  input  logic              i_m1_lock,
  output logic              o_m0_gnt,
  output logic              o_m1_gnt,
  output logic              o_m0_rvalid,
  output logic              o_m1_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_m0_err,
  output logic              o_m1_err,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  // 17 bits hold any depth up to 2^16, which covers the full 16-bit address.
  localparam logic [16:0] DEPTH_L = 17'(RAM_DEPTH);

  typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_t;

  owner_t owner_q, owner_d;
  logic   m0_first;
  logic   xfer0, xfer1;
  logic   in_range0, in_range1;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 means master 1 won most recently, so master 0 wins the next conflict.
  logic last_m1_q;

  // Last-winner pointer. It moves on every granted transfer.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)  last_m1_q <= 1'b1;
    else if (xfer0)  last_m1_q <= 1'b0;
    else if (xfer1)  last_m1_q <= 1'b1;
  end

  assign m0_first = last_m1_q;
`else
  assign m0_first = 1'b1;
`endif

  assign in_range0 = ({1'b0, i_m0_addr} < DEPTH_L);
  assign in_range1 = ({1'b0, i_m1_addr} < DEPTH_L);
  assign xfer0     = i_m0_req & o_m0_gnt;
  assign xfer1     = i_m1_req & o_m1_gnt;
  assign o_rdata   = i_ram_rdata;

  // Grant decision. A lock owner keeps its grant even while it is not requesting.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    o_m0_gnt = 1'b0;
    o_m1_gnt = 1'b0;
    if (i_reset_n) begin
      unique case (owner_q)
        OWN_M0: o_m0_gnt = 1'b1;
        OWN_M1: o_m1_gnt = 1'b1;
        default: begin
          if (i_m0_req && i_m1_req) begin
            o_m0_gnt = m0_first;
            o_m1_gnt = !m0_first;
          end else begin
            o_m0_gnt = i_m0_req;
            o_m1_gnt = i_m1_req;
          end
        end
      endcase
    end
  end

  // RAM port mux. Only a granted, in-range transfer reaches the RAM.
  always_comb begin
    o_ram_we    = 1'b0;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    if (xfer0 && in_range0) begin
      o_ram_we    = i_m0_we;
      o_ram_addr  = i_m0_addr[ADDR_W-1:0];
      o_ram_wdata = i_m0_wdata;
    end else if (xfer1 && in_range1) begin
      o_ram_we    = i_m1_we;
      o_ram_addr  = i_m1_addr[ADDR_W-1:0];
      o_ram_wdata = i_m1_wdata;
    end
  end

  // Lock-owner next state: acquire on a locked transfer, release when lock drops.
  always_comb begin
    owner_d = owner_q;
    unique case (owner_q)
      OWN_M0: if (!i_m0_lock) owner_d = OWN_NONE;
      OWN_M1: if (!i_m1_lock) owner_d = OWN_NONE;
      default: begin
        if (xfer0 && i_m0_lock)      owner_d = OWN_M0;
        else if (xfer1 && i_m1_lock) owner_d = OWN_M1;
      end
    endcase
  end

  // Lock-owner state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!i_reset_n) owner_q <= OWN_NONE;
    else            owner_q <= owner_d;
  end

  // Per-master responses, one cycle after the transfer.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_m0_rvalid <= 1'b0;
      o_m1_rvalid <= 1'b0;
      o_m0_err    <= 1'b0;
      o_m1_err    <= 1'b0;
    end else begin
      o_m0_rvalid <= xfer0 & in_range0 & ~i_m0_we;
      o_m1_rvalid <= xfer1 & in_range1 & ~i_m1_we;
      o_m0_err    <= xfer0 & ~in_range0;
      o_m1_err    <= xfer1 & ~in_range1;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with a synchronous RAM model,
// a rule-level reference model checked on every falling edge, and literal
// expectations for the key scenarios.
`timescale 1ns/1ps
module tb_ram_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req = '0, we = '0, lock = '0;
  logic [15:0] addr [2];
  logic [DATA_W-1:0] wdata [2];

  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, ram_we;
  logic [DATA_W-1:0] rdata, ram_wdata, ram_rdata;
  logic [ADDR_W-1:0] ram_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_m0_req(req[0]), .i_m0_we(we[0]), .i_m0_addr(addr[0]), .i_m0_wdata(wdata[0]), .i_m0_lock(lock[0]),
    .i_m1_req(req[1]), .i_m1_we(we[1]), .i_m1_addr(addr[1]), .i_m1_wdata(wdata[1]), .i_m1_lock(lock[1]),
    .o_m0_gnt(m0_gnt), .o_m1_gnt(m1_gnt),
    .o_m0_rvalid(m0_rvalid), .o_m1_rvalid(m1_rvalid), .o_rdata(rdata),
    .o_m0_err(m0_err), .o_m1_err(m1_err),
    .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata)
  );

  // Synchronous single-port RAM, read-before-write.
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  // Reference model: the owner is -1 when no master holds the lock.
  logic [DATA_W-1:0] mdl_mem [DEPTH];
  int   m_owner = -1;
  int   m_last  = 1;
  logic [1:0] m_rv = '0, m_err = '0;
  logic [DATA_W-1:0] m_rdata = '0;

  function automatic bit in_range(input logic [15:0] a);
    return int'(a) < DEPTH;
  endfunction

  function automatic int exp_winner();
    if (!rst_n) return -1;
    if (m_owner >= 0) return m_owner;
    if (req[0] && req[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
      return (m_last == 1) ? 0 : 1;
`else
      return 0;
`endif
    end
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : model_update
    int w;
    if (!rst_n) begin
      m_owner <= -1;
      m_last  <= 1;
      m_rv    <= '0;
      m_err   <= '0;
    end else begin
      w = exp_winner();
      m_rv  <= '0;
      m_err <= '0;
      if (w >= 0 && req[w]) begin
        m_last <= w;
        if (!in_range(addr[w])) m_err[w] <= 1'b1;
        else if (we[w]) mdl_mem[addr[w][ADDR_W-1:0]] <= wdata[w];
        else begin
          m_rv[w] <= 1'b1;
          m_rdata <= mdl_mem[addr[w][ADDR_W-1:0]];
        end
      end
      if (m_owner >= 0) begin
        if (!lock[m_owner]) m_owner <= -1;
      end else if (w >= 0 && req[w] && lock[w]) begin
        m_owner <= w;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin : compare
    int w;
    bit drive_ram;
    w = exp_winner();
    drive_ram = (w >= 0) && req[w] && in_range(addr[w]);
    check("gnt0", 32'(m0_gnt), 32'(w == 0));
    check("gnt1", 32'(m1_gnt), 32'(w == 1));
    check("ram_we", 32'(ram_we), 32'(drive_ram && we[w]));
    check("ram_addr", 32'(ram_addr), drive_ram ? 32'(addr[w][ADDR_W-1:0]) : 32'd0);
    check("ram_wdata", 32'(ram_wdata), drive_ram ? 32'(wdata[w]) : 32'd0);
    check("rvalid0", 32'(m0_rvalid), 32'(m_rv[0]));
    check("rvalid1", 32'(m1_rvalid), 32'(m_rv[1]));
    check("err0", 32'(m0_err), 32'(m_err[0]));
    check("err1", 32'(m1_err), 32'(m_err[1]));
    if (m_rv != 2'b00) check("rdata", 32'(rdata), 32'(m_rdata));
  end

  task automatic drive(input int m, input logic r, input logic w, input logic [15:0] a,
                       input logic [DATA_W-1:0] d, input logic l);
    req[m] = r; we[m] = w; addr[m] = a; wdata[m] = d; lock[m] = l;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  logic [3:0] exp_rr;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = DATA_W'(i * 7) ^ 16'h0a5a;
      mdl_mem[i] = DATA_W'(i * 7) ^ 16'h0a5a;
    end
    ram[5] = 16'h1234;
    mdl_mem[5] = 16'h1234;
    drive(0, 1'b1, 1'b1, 16'h0001, 16'h1111, 1'b1);
    drive(1, 1'b1, 1'b1, 16'h0002, 16'h2222, 1'b1);

    // Reset holds grants and RAM outputs at zero even with requests present.
    sample();
    check("rst_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
    check("rst_ram", 32'({ram_we, ram_addr, ram_wdata}), 32'd0);
    check("rst_resp", 32'({m0_rvalid, m1_rvalid, m0_err, m1_err}), 32'd0);
    next_cycle();

    // Both masters read for four cycles with no locks.
    rst_n = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    exp_rr = 4'b0101;
`else
    exp_rr = 4'b1111;
`endif
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 1'b0, 16'(i + 1), 16'h0, 1'b0);
      drive(1, 1'b1, 1'b0, 16'(i + 8), 16'h0, 1'b0);
      sample();
      check("conflict_gnt0", 32'(m0_gnt), 32'(exp_rr[i]));
      check("conflict_gnt1", 32'(m1_gnt), 32'(!exp_rr[i]));
      next_cycle();
    end

    // A lone master 0 reads address 5.
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(0, 1'b1, 1'b0, 16'h0005, 16'h0, 1'b0);
    sample();
    check("rd5_gnt0", 32'(m0_gnt), 32'd1);
    check("rd5_addr", 32'(ram_addr), 32'h005);
    next_cycle();
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    sample();
    check("rd5_rvalid", 32'(m0_rvalid), 32'd1);
    check("rd5_rdata", 32'(rdata), 32'h1234);
    next_cycle();

    // Master 1 takes the lock with a write, then idles while holding it.
    drive(1, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b1);
    sample();
    check("lock_wr_gnt1", 32'(m1_gnt), 32'd1);
    check("lock_wr_ram", 32'({ram_we, ram_addr, ram_wdata}), {5'd0, 1'b1, 10'h010, 16'hBEEF});
    next_cycle();
    drive(0, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
      sample();
      check("locked_gnt1", 32'(m1_gnt), 32'd1);
      check("locked_gnt0", 32'(m0_gnt), 32'd0);
      check("locked_ram_we", 32'(ram_we), 32'd0);
      next_cycle();
    end
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    sample();
    check("unlock_cycle_gnt1", 32'(m1_gnt), 32'd1);
    next_cycle();
    sample();
    check("after_unlock_gnt0", 32'(m0_gnt), 32'd1);
    next_cycle();
    drive(0, 1'b1, 1'b0, 16'h03FF, 16'h0, 1'b0);
    sample();
    check("readback_rdata", 32'(rdata), 32'hBEEF);
    check("readback_rvalid", 32'(m0_rvalid), 32'd1);
    check("top_addr", 32'(ram_addr), 32'h3FF);
    next_cycle();

    // Master 0 reads just past the end of the RAM.
    drive(0, 1'b1, 1'b0, 16'h0400, 16'h0, 1'b0);
    sample();
    check("oor_gnt0", 32'(m0_gnt), 32'd1);
    check("oor_ram", 32'({ram_we, ram_addr}), 32'd0);
    next_cycle();
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    sample();
    check("oor_err0", 32'(m0_err), 32'd1);
    check("oor_rvalid0", 32'(m0_rvalid), 32'd0);
    next_cycle();
    sample();
    check("oor_err0_clear", 32'(m0_err), 32'd0);
    next_cycle();

    // Master 1 out-of-range write, then in-range write and readback.
    drive(1, 1'b1, 1'b1, 16'hF000, 16'hAAAA, 1'b0);
    next_cycle();
    drive(1, 1'b1, 1'b1, 16'h0123, 16'h5A5A, 1'b0);
    sample();
    check("oor_err1", 32'(m1_err), 32'd1);
    next_cycle();
    drive(1, 1'b1, 1'b0, 16'h0123, 16'h0, 1'b0);
    sample();
    check("wr_no_rvalid1", 32'(m1_rvalid), 32'd0);
    next_cycle();
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    sample();
    check("wr_readback", 32'(rdata), 32'h5A5A);
    next_cycle();

    // A locked m1 read is granted, then reset lands in the following cycle.
    drive(1, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b1);
    sample();
    check("pre_rst_gnt1", 32'(m1_gnt), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    sample();
    check("rst_kills_rvalid1", 32'(m1_rvalid), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b0, 16'h0007, 16'h0, 1'b0);
    drive(1, 1'b1, 1'b0, 16'h0008, 16'h0, 1'b0);
    sample();
    check("post_rst_gnt0", 32'(m0_gnt), 32'd1);
    check("post_rst_gnt1", 32'(m1_gnt), 32'd0);
    next_cycle();
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (2) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width of the shared RAM.
REQ-002 SHALL have parameter DATA_W, default 16, data word width.
REQ-003 SHALL have parameter RAM_DEPTH, default 1024, number of implemented RAM words; legal range is 1 to 2^ADDR_W.
REQ-004 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 i_reset_n  input  1  asynchronous, active-low reset.
REQ-006 i_m0_req / i_m1_req  input  1  access request from master 0 (CPU) / master 1 (loader/DMA).
REQ-007 i_m0_we / i_m1_we  input  1  1 = write, 0 = read.
REQ-008 i_m0_addr / i_m1_addr  input  16  word address.
REQ-009 i_m0_wdata / i_m1_wdata  input  DATA_W  write data.
REQ-010 i_m0_lock / i_m1_lock  input  1  hold exclusive ownership after a granted transfer.
REQ-011 o_m0_gnt / o_m1_gnt  output  1  combinational grant; transfer occurs when req and gnt are both 1.
REQ-012 o_m0_rvalid / o_m1_rvalid  output  1  registered; read data valid, one cycle after the granted read.
REQ-013 o_rdata  output  DATA_W  shared read data, equal to i_ram_rdata.
REQ-014 o_m0_err / o_m1_err  output  1  registered; one-cycle pulse after a granted out-of-range access.
REQ-015 o_ram_we  output  1  RAM write enable.
REQ-016 o_ram_addr  output  ADDR_W  RAM word address.
REQ-017 o_ram_wdata  output  DATA_W  RAM write data.
REQ-018 i_ram_rdata  input  DATA_W  RAM read data, returned one cycle after the address (synchronous RAM).

Function
REQ-019 At most one of o_m0_gnt and o_m1_gnt SHALL be 1 in any cycle.
REQ-020 A grant SHALL be issued only to a requesting master, except as allowed by REQ-023.
- The grant is decided combinationally from the requests, the lock owner and the priority state.
REQ-021 With a single requester, that master SHALL be granted in the same cycle, unless the other master owns the lock.
REQ-022 With both masters requesting and no lock owner, the winner SHALL be chosen per REQ-030/REQ-031.
REQ-023 While a master is the lock owner, only it SHALL be granted.
- Its o_mX_gnt SHALL remain 1 even when its req is 0.
- The other master's o_mX_gnt SHALL be 0.
REQ-024 A master SHALL become lock owner at the clock edge that ends a granted transfer during which its lock input is 1.
- Ownership SHALL be released at the first clock edge where the owner's lock input is 0.
REQ-025 For a granted, in-range transfer (address < RAM_DEPTH), the RAM outputs SHALL be driven from the winning master in the same cycle:
- o_ram_addr = addr[ADDR_W-1:0]
- o_ram_wdata = wdata
- o_ram_we = we
REQ-026 With no granted in-range transfer in a cycle, the RAM outputs SHALL be o_ram_we = 0, o_ram_addr = 0 and o_ram_wdata = 0.
REQ-027 A granted read SHALL raise that master's o_mX_rvalid for exactly one cycle, in the cycle after the grant.
- Back-to-back reads SHALL produce back-to-back rvalid pulses.
REQ-028 A granted access with address >= RAM_DEPTH SHALL NOT drive the RAM (o_ram_we = 0).
- It SHALL produce no rvalid.
- It SHALL pulse that master's o_mX_err for one cycle, in the cycle after the grant.
REQ-029 A granted write SHALL produce no rvalid.

Configuration
REQ-030 With macro ARB_ROUND_ROBIN_EN defined, priority SHALL be round-robin.
- A registered last-winner pointer is updated on every granted transfer.
- On a conflict, the master that is not the last winner SHALL be granted.
REQ-031 With ARB_ROUND_ROBIN_EN undefined, priority SHALL be fixed: master 0 wins every conflict.
- The last-winner pointer SHALL NOT be implemented.
- Lock behaviour SHALL be the same as in REQ-023/REQ-024.

Reset
REQ-032 Assertion of i_reset_n = 0 SHALL immediately, without waiting for a clock edge:
- clear the lock owner;
- set o_m0_rvalid, o_m1_rvalid, o_m0_err and o_m1_err to 0;
- set the last-winner pointer to master 1, so master 0 wins the first conflict.
REQ-033 While i_reset_n = 0, both grants SHALL be 0 and the RAM outputs SHALL be 0.
REQ-034 Reset during a pending read SHALL suppress that read's rvalid pulse.
REQ-035 After i_reset_n is released, normal arbitration SHALL resume on the first rising clock edge.

Verification
REQ-036 m0 reads address 0x005 alone, RAM holds 0x1234 there -> o_m0_gnt = 1 in the same cycle, o_ram_addr = 0x005, o_m0_rvalid = 1 next cycle with o_rdata = 0x1234.
REQ-037 Both masters request for 4 cycles, no locks, with ARB_ROUND_ROBIN_EN -> grants are m0, m1, m0, m1; without the macro -> m0 on all 4 cycles.
REQ-038 m1 writes 0xBEEF to 0x010 with lock = 1, then drops req for 2 cycles while keeping lock = 1, while m0 requests throughout -> o_m1_gnt = 1 and o_m0_gnt = 0 for those cycles; m0 is granted the cycle after m1 drops lock.
REQ-039 m0 reads address 0x0400 -> o_ram_we = 0, o_m0_err = 1 for one cycle, no rvalid.
REQ-040 Assert reset in the cycle after a granted m1 read -> o_m1_rvalid stays 0, lock owner is cleared, and the first post-reset conflict is granted to m0.
